// File: rtl/microcode_sequencer_if.sv
// microcode_sequencer_if: fetch-side handshake and decode-control bundle for the microcode sequencer.
//   master (fetch / stimulus): drives instr, instr_valid, stall, zero; observes ready and controls.
//   slave (sequencer): observes instr, instr_valid, stall, zero; drives instr_ready and all controls.
interface microcode_sequencer_if #(
    parameter int DW  = 4,
    parameter int OPW = 4,
    parameter int RW  = 4,
    parameter int AW  = 4
);
    logic [OPW+DW-1:0] instr;
    logic              instr_valid;
    logic              instr_ready;
    logic              stall;
    logic              zero;
    logic [RW-1:0]     instr_r;
    logic [AW-1:0]     instr_a;
    logic [DW-1:0]     imm;
    logic              imm_oe;
    logic              mem_rd;
    logic              pc_load;
    logic              illegal;
    modport master (
        output instr, instr_valid, stall, zero,
        input  instr_ready, instr_r, instr_a, imm, imm_oe, mem_rd, pc_load, illegal
    );
    modport slave (
        input  instr, instr_valid, stall, zero,
        output instr_ready, instr_r, instr_a, imm, imm_oe, mem_rd, pc_load, illegal
    );
endinterface

// File: rtl/microcode_sequencer.sv
// microcode_sequencer: expands each accepted instruction into 1-2 registered micro-steps of decode controls.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of microcode_sequencer_if (instr/valid/ready handshake, stall, zero flag,
//           instr_r, instr_a, imm, imm_oe, mem_rd, pc_load, sticky illegal)
module microcode_sequencer #(
    parameter int DW  = 4,
    parameter int OPW = 4,
    parameter int RW  = 4,
    parameter int AW  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    microcode_sequencer_if.slave  bus
);
    typedef enum logic {IDLE, EXEC} state_t;
    typedef struct packed {
        logic          two;
        logic [RW-1:0] r;
        logic [AW-1:0] a;
        logic [DW-1:0] imm;
        logic          imm_oe;
        logic          mem_rd;
        logic          pc_load;
    } ctl_t;
    state_t         state_q;
    logic           step_q;
    logic           illegal_q;
    logic [OPW-1:0] op_q;
    logic [DW-1:0]  v_q;
    ctl_t           ctl_q;
    ctl_t           ctl0_d;
    ctl_t           ctl1_d;
    logic           last;
    logic           accept;
    logic [OPW-1:0] op_in;
    logic [DW-1:0]  v_in;
    // Any opcode bit above bit 3 is illegal regardless of the low nibble.
    function automatic logic is_legal(input logic [OPW-1:0] op);
        logic [3:0] lo;
        lo = op[3:0];
        return ((op >> 4) == '0) && (lo inside {4'h0, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'hB, 4'hF});
    endfunction
    // Controls for one micro-step; 'two' marks instructions that need a second step.
    function automatic ctl_t decode(input logic [OPW-1:0] op, input logic [DW-1:0] v,
                                    input logic st, input logic z);
        ctl_t       c;
        logic [3:0] lo;
        c  = '0;
        lo = op[3:0];
        if (is_legal(op)) begin
            case (lo)
                4'h0: begin
                    if (v[DW-1]) begin
                        c.two = 1'b1;
                        if (st) c.r = RW'(4);
                        else    c.a = AW'(v);
                    end else begin
                        c.r = RW'({1'b1, v[2:0]});
                    end
                end
                4'h2, 4'h4, 4'h6: begin
                    c.imm    = v;
                    c.imm_oe = 1'b1;
                    c.r      = RW'(lo[3:1]);
                end
                4'h3: begin
                    c.imm     = v;
                    c.pc_load = ~z;
                end
                4'h7: begin
                    c.imm     = v;
                    c.pc_load = 1'b1;
                end
                4'hB, 4'hF: begin
                    c.two = 1'b1;
                    if (st) begin
                        c.r = (lo == 4'hB) ? RW'(1) : RW'(4);
                    end else begin
                        c.imm    = v;
                        c.mem_rd = 1'b1;
                    end
                end
                default: c = '0;
            endcase
        end
        return c;
    endfunction
    assign op_in           = bus.instr[OPW+DW-1:DW];
    assign v_in            = bus.instr[DW-1:0];
    assign last            = step_q | ~ctl_q.two;
    assign bus.instr_ready = (state_q == IDLE) | ((state_q == EXEC) & last & ~bus.stall);
    assign accept          = bus.instr_valid & bus.instr_ready;
    // zero is captured only on the accepting edge, so a stalled JNZ keeps its decision.
    assign ctl0_d          = decode(op_in, v_in, 1'b0, bus.zero);
    assign ctl1_d          = decode(op_q, v_q, 1'b1, 1'b0);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            step_q    <= 1'b0;
            ctl_q     <= '0;
            op_q      <= '0;
            v_q       <= '0;
            illegal_q <= 1'b0;
        end else if (!((state_q == EXEC) && bus.stall)) begin
            if (accept) begin
                state_q   <= EXEC;
                step_q    <= 1'b0;
                op_q      <= op_in;
                v_q       <= v_in;
                ctl_q     <= ctl0_d;
                illegal_q <= illegal_q | ~is_legal(op_in);
            end else if ((state_q == EXEC) && !last) begin
                step_q <= 1'b1;
                ctl_q  <= ctl1_d;
            end else begin
                state_q <= IDLE;
                step_q  <= 1'b0;
                ctl_q   <= '0;
            end
        end
    end
    assign bus.instr_r = ctl_q.r;
    assign bus.instr_a = ctl_q.a;
    assign bus.imm     = ctl_q.imm;
    assign bus.imm_oe  = ctl_q.imm_oe;
    assign bus.mem_rd  = ctl_q.mem_rd;
    assign bus.pc_load = ctl_q.pc_load;
    assign bus.illegal = illegal_q;
endmodule
